multicycle_control_unit: RTL and testbench

Parametrised successor of the processor's multi-cycle control FSM. It sequences fetch/decode/execute/memory/write-back and drives the program counter, instruction decoder, register file and external memory strobes. New over the previous generation:
- all opcode classes executed: RRR, RRD, RRS, RIMM (load), IMM (jump, optionally flag-conditional)
- memory wait-state handshake with a timeout fault
- illegal-opcode reporting
- retired-instruction counter

---
 rtl/multicycle_control_unit.sv | 242 ++++++++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_unit.sv
// Multi-cycle control FSM: sequences fetch/decode/execute/memory/write-back for the core.
// Latency: zero-wait instructions take 3 (jump), 4 (RRR/RIMM/RRS) or 5 (RRD) cycles.
// Backpressure: FETCH and MEM stall on mem_ready; a stall of WAIT_MAX cycles faults (0 = never).
module multicycle_control_unit #(
    parameter int OPCODE_W     = 4,
    parameter int WAIT_MAX     = 15,
    parameter bit COND_JUMP    = 1'b1,
    parameter bit TRAP_ILLEGAL = 1'b0,
    parameter int CNT_W        = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                flag,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    output logic                inst_wr,
    output logic                decoder_en,
    output logic [1:0]          pc_op,
    output logic                reg_en,
    output logic                rD_wr,
    output logic                imm_en,
    output logic                adrs_ctrl,
    output logic                mem_rd,
    output logic                mem_wr,
    output logic                illegal_op,
    output logic                fault,
    output logic [CNT_W-1:0]    instr_count
);

    // Program counter operations.
    localparam logic [1:0] PC_RESET  = 2'd0;
    localparam logic [1:0] PC_PRESET = 2'd1;
    localparam logic [1:0] PC_INCR   = 2'd2;
    localparam logic [1:0] PC_HALT   = 2'd3;

    // The wait counter only has to represent 0..WAIT_MAX-1: the cycle that would
    // push it to WAIT_MAX is the one that decides the timeout.
    localparam int              WAIT_W    = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((WAIT_MAX > 0) ? (WAIT_MAX - 1) : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_MEM,
        S_WRITE_BACK,
        S_FAULT
    } state_e;

    typedef enum logic [2:0] {
        CLS_RRR,
        CLS_RRD,
        CLS_RRS,
        CLS_RIMM,
        CLS_IMM,
        CLS_ILL
    } cls_e;

    // Map an opcode to its execution class; anything outside the 4-bit map is illegal.
    function automatic cls_e classify(input logic [OPCODE_W-1:0] op);
        cls_e       c;
        logic [3:0] lo;
        lo = op[3:0];
        c  = CLS_ILL;
        if ((op >> 4) == '0) begin
            case (lo)
                4'b0001: c = CLS_RRD;
                4'b0010: c = CLS_RRS;
                4'b0011: c = CLS_RIMM;
                4'b0101: c = CLS_IMM;
                4'b1011: c = CLS_ILL;
                default: c = CLS_RRR;
            endcase
        end
        return c;
    endfunction

    state_e              state_q, state_d;
    logic [OPCODE_W-1:0] op_q, op_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    cls_e                op_cls;
    logic                retire;
    logic                timeout_hit;

    assign op_cls      = classify(op_q);
    assign timeout_hit = (WAIT_MAX > 0) && (wait_q == WAIT_LAST);

    // State, latched opcode, wait counter and retire counter registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            wait_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            wait_q  <= wait_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and control strobes; memory-facing strobes are Mealy on mem_ready.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        wait_d     = '0;
        retire     = 1'b0;
        inst_wr    = 1'b0;
        decoder_en = 1'b0;
        pc_op      = PC_HALT;
        reg_en     = 1'b0;
        rD_wr      = 1'b0;
        imm_en     = 1'b0;
        adrs_ctrl  = 1'b0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        illegal_op = 1'b0;
        fault      = 1'b0;

        case (state_q)
            S_IDLE: begin
                pc_op   = PC_RESET;
                state_d = S_FETCH;
            end

            S_FETCH: begin
                mem_rd = 1'b1;
                if (mem_ready) begin
                    inst_wr = 1'b1;
                    pc_op   = PC_INCR;
                    state_d = S_DECODE;
                end else if (timeout_hit) begin
                    state_d = S_FAULT;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end

            S_DECODE: begin
                decoder_en = 1'b1;
                op_d       = opcode;
                state_d    = S_EXECUTE;
            end

            S_EXECUTE: begin
                case (op_cls)
                    CLS_RRR: begin
                        reg_en  = 1'b1;
                        state_d = S_WRITE_BACK;
                    end
                    CLS_RRD, CLS_RRS: begin
                        reg_en    = 1'b1;
                        adrs_ctrl = 1'b1;
                        state_d   = S_MEM;
                    end
                    CLS_RIMM: begin
                        imm_en  = 1'b1;
                        state_d = S_WRITE_BACK;
                    end
                    CLS_IMM: begin
                        pc_op   = (flag || !COND_JUMP) ? PC_PRESET : PC_HALT;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                    default: begin
                        illegal_op = 1'b1;
                        state_d    = TRAP_ILLEGAL ? S_FAULT : S_FETCH;
                    end
                endcase
            end

            S_MEM: begin
                // Address and register file stay pointed at rA for the whole access.
                reg_en    = 1'b1;
                adrs_ctrl = 1'b1;
                if (op_cls == CLS_RRS) begin
                    mem_wr = 1'b1;
                end else begin
                    mem_rd = 1'b1;
                end
                if (mem_ready) begin
                    if (op_cls == CLS_RRS) begin
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WRITE_BACK;
                    end
                end else if (timeout_hit) begin
                    state_d = S_FAULT;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end

            S_WRITE_BACK: begin
                reg_en  = 1'b1;
                rD_wr   = 1'b1;
                imm_en  = (op_cls == CLS_RIMM);
                retire  = 1'b1;
                state_d = S_FETCH;
            end

            S_FAULT: begin
                fault = 1'b1;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        cnt_d = retire ? (cnt_q + CNT_W'(1)) : cnt_q;

        // Outputs are quiet for the whole reset window, not only after the first edge.
        if (reset) begin
            inst_wr    = 1'b0;
            decoder_en = 1'b0;
            pc_op      = PC_RESET;
            reg_en     = 1'b0;
            rD_wr      = 1'b0;
            imm_en     = 1'b0;
            adrs_ctrl  = 1'b0;
            mem_rd     = 1'b0;
            mem_wr     = 1'b0;
            illegal_op = 1'b0;
            fault      = 1'b0;
        end
    end

    // Retired-instruction count, held at zero while reset is asserted.
    assign instr_count = reset ? '0 : cnt_q;

    // A single access direction at a time on the external bus.
    a_rd_wr_exclusive: assert property (@(posedge clock) !(mem_rd && mem_wr));

    // A faulted unit never moves the program counter.
    a_fault_halts: assert property (@(posedge clock) fault |-> (pc_op == PC_HALT));

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: two configurations driven with shared inputs.
// Expected strobes come from per-class instruction scripts; memory waits are bench-chosen.
// Inputs change #1 after posedge, outputs are sampled on the falling edge.
module tb_multicycle_control_unit;

    localparam int C_RRR  = 0;
    localparam int C_RRD  = 1;
    localparam int C_RRS  = 2;
    localparam int C_RIMM = 3;
    localparam int C_IMM  = 4;
    localparam int C_ILL  = 5;

    // Configuration 0: WAIT_MAX=4, conditional jump, skip illegal, 16-bit count.
    // Configuration 1: no timeout, unconditional jump, trap illegal, 2-bit count.
    int          wait_max_c [2] = '{4, 0};
    bit          cond_c     [2] = '{1'b1, 1'b0};
    bit          trap_c     [2] = '{1'b0, 1'b1};
    logic [15:0] mask_c     [2] = '{16'hFFFF, 16'h0003};

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       reset;
    logic       flag;
    logic [3:0] opcode;
    logic       mem_ready;

    logic        a_inst_wr, a_decoder_en, a_reg_en, a_rD_wr, a_imm_en, a_adrs_ctrl;
    logic        a_mem_rd, a_mem_wr, a_illegal_op, a_fault;
    logic [1:0]  a_pc_op;
    logic [15:0] a_cnt;
    logic        b_inst_wr, b_decoder_en, b_reg_en, b_rD_wr, b_imm_en, b_adrs_ctrl;
    logic        b_mem_rd, b_mem_wr, b_illegal_op, b_fault;
    logic [1:0]  b_pc_op;
    logic [1:0]  b_cnt;

    multicycle_control_unit #(
        .OPCODE_W(4), .WAIT_MAX(4), .COND_JUMP(1'b1), .TRAP_ILLEGAL(1'b0), .CNT_W(16)
    ) dut_a (
        .clock(clock), .reset(reset), .flag(flag), .opcode(opcode), .mem_ready(mem_ready),
        .inst_wr(a_inst_wr), .decoder_en(a_decoder_en), .pc_op(a_pc_op), .reg_en(a_reg_en),
        .rD_wr(a_rD_wr), .imm_en(a_imm_en), .adrs_ctrl(a_adrs_ctrl), .mem_rd(a_mem_rd),
        .mem_wr(a_mem_wr), .illegal_op(a_illegal_op), .fault(a_fault), .instr_count(a_cnt)
    );

    multicycle_control_unit #(
        .OPCODE_W(4), .WAIT_MAX(0), .COND_JUMP(1'b0), .TRAP_ILLEGAL(1'b1), .CNT_W(2)
    ) dut_b (
        .clock(clock), .reset(reset), .flag(flag), .opcode(opcode), .mem_ready(mem_ready),
        .inst_wr(b_inst_wr), .decoder_en(b_decoder_en), .pc_op(b_pc_op), .reg_en(b_reg_en),
        .rD_wr(b_rD_wr), .imm_en(b_imm_en), .adrs_ctrl(b_adrs_ctrl), .mem_rd(b_mem_rd),
        .mem_wr(b_mem_wr), .illegal_op(b_illegal_op), .fault(b_fault), .instr_count(b_cnt)
    );

    int          sel;
    int          errors;
    int          checks;
    logic [15:0] mcnt;
    bit          faulted;

    // Observed outputs of the selected instance: {count, 4'h0, 12 control bits}.
    function automatic logic [31:0] observe(input int s);
        if (s == 0)
            return {a_cnt, 4'h0, a_inst_wr, a_decoder_en, a_pc_op, a_reg_en, a_rD_wr, a_imm_en,
                    a_adrs_ctrl, a_mem_rd, a_mem_wr, a_illegal_op, a_fault};
        return {14'h0, b_cnt, 4'h0, b_inst_wr, b_decoder_en, b_pc_op, b_reg_en, b_rD_wr, b_imm_en,
                b_adrs_ctrl, b_mem_rd, b_mem_wr, b_illegal_op, b_fault};
    endfunction

    function automatic logic [11:0] mk(input bit iw, input bit dec, input logic [1:0] pc,
                                       input bit re, input bit rd, input bit im, input bit ad,
                                       input bit mr, input bit mw, input bit il, input bit fl);
        return {iw, dec, pc, re, rd, im, ad, mr, mw, il, fl};
    endfunction

    function automatic int cls_of(input logic [3:0] op);
        case (op)
            4'b0001: return C_RRD;
            4'b0010: return C_RRS;
            4'b0011: return C_RIMM;
            4'b0101: return C_IMM;
            4'b1011: return C_ILL;
            default: return C_RRR;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s (cfg %0d, t=%0t): got %h expected %h", tag, sel, $time, got, exp);
        end
    endtask

    // Compare one cycle of outputs against the expected strobes and model count.
    task automatic cyc(input string tag, input logic [11:0] ctl);
        @(negedge clock);
        check(tag, observe(sel), {mcnt & mask_c[sel], 4'h0, ctl});
        @(posedge clock);
        #1;
    endtask

    task automatic rnd_inputs();
        flag      = 1'($urandom);
        mem_ready = 1'($urandom);
        opcode    = 4'($urandom);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        mcnt  = '0;
        for (int i = 0; i < n; i++) begin
            rnd_inputs();
            cyc("reset", 12'h000);
        end
        reset = 1'b0;
        rnd_inputs();
        cyc("idle", 12'h000);
        faulted = 1'b0;
    endtask

    task automatic fault_hold(input int n);
        faulted = 1'b1;
        for (int i = 0; i < n; i++) begin
            rnd_inputs();
            cyc("fault_hold", mk(0, 0, 2'd3, 0, 0, 0, 0, 0, 0, 0, 1));
        end
    endtask

    task automatic write_back(input bit im);
        rnd_inputs();
        cyc("write_back", mk(0, 0, 2'd3, 1, 1, im, 0, 0, 0, 0, 0));
        mcnt++;
    endtask

    // One instruction from FETCH onward: fw/mw = mem_ready-low cycles in FETCH/MEM,
    // rst_at = MEM wait index at which reset is asserted instead (-1 = never).
    task automatic run_instr(input logic [3:0] op, input bit fl, input int fw, input int mw,
                             input int rst_at);
        int c;
        bit rdc;
        if (faulted) return;
        for (int i = 0; i <= fw; i++) begin
            rnd_inputs();
            mem_ready = (i == fw);
            if (i == fw) begin
                cyc("fetch_done", mk(1, 0, 2'd2, 0, 0, 0, 0, 1, 0, 0, 0));
            end else begin
                cyc("fetch_wait", mk(0, 0, 2'd3, 0, 0, 0, 0, 1, 0, 0, 0));
                if (wait_max_c[sel] > 0 && i + 1 == wait_max_c[sel]) begin
                    fault_hold(3);
                    return;
                end
            end
        end
        rnd_inputs();
        opcode = op;
        cyc("decode", mk(0, 1, 2'd3, 0, 0, 0, 0, 0, 0, 0, 0));
        rnd_inputs();
        flag = fl;
        c = cls_of(op);
        case (c)
            C_RRR: begin
                cyc("ex_rrr", mk(0, 0, 2'd3, 1, 0, 0, 0, 0, 0, 0, 0));
                write_back(1'b0);
            end
            C_RIMM: begin
                cyc("ex_rimm", mk(0, 0, 2'd3, 0, 0, 1, 0, 0, 0, 0, 0));
                write_back(1'b1);
            end
            C_IMM: begin
                cyc("ex_jump", mk(0, 0, (fl || !cond_c[sel]) ? 2'd1 : 2'd3, 0, 0, 0, 0, 0, 0, 0, 0));
                mcnt++;
            end
            C_ILL: begin
                cyc("ex_illegal", mk(0, 0, 2'd3, 0, 0, 0, 0, 0, 0, 1, 0));
                if (trap_c[sel]) fault_hold(3);
            end
            default: begin
                rdc = (c == C_RRD);
                cyc("ex_mem", mk(0, 0, 2'd3, 1, 0, 0, 1, 0, 0, 0, 0));
                for (int i = 0; i <= mw; i++) begin
                    rnd_inputs();
                    mem_ready = (i == mw);
                    if (i == rst_at) begin
                        do_reset(2);
                        return;
                    end
                    cyc(rdc ? "mem_rd" : "mem_wr", mk(0, 0, 2'd3, 1, 0, 0, 1, rdc, !rdc, 0, 0));
                    if (i == mw) begin
                        if (rdc) write_back(1'b0);
                        else     mcnt++;
                    end else if (wait_max_c[sel] > 0 && i + 1 == wait_max_c[sel]) begin
                        fault_hold(3);
                        return;
                    end
                end
            end
        endcase
    endtask

    task automatic random_run(input int n);
        for (int k = 0; k < n; k++) begin
            if (faulted) do_reset(2);
            run_instr(4'($urandom), 1'($urandom), int'($urandom_range(0, 5)),
                      int'($urandom_range(0, 5)), -1);
        end
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        sel       = 0;
        mcnt      = '0;
        faulted   = 1'b0;
        reset     = 1'b1;
        flag      = 1'b0;
        opcode    = 4'h0;
        mem_ready = 1'b1;

        // Configuration 0: directed cases, then random instruction stream.
        sel = 0;
        do_reset(2);
        repeat (3) run_instr(4'b0000, 1'b0, 0, 0, -1);
        run_instr(4'b0001, 1'b0, 0, 3, -1);
        run_instr(4'b0010, 1'b0, 0, 3, -1);
        run_instr(4'b0101, 1'b1, 0, 0, -1);
        run_instr(4'b0101, 1'b0, 0, 0, -1);
        run_instr(4'b0011, 1'b0, 0, 0, -1);
        run_instr(4'b1011, 1'b0, 0, 0, -1);
        run_instr(4'b0000, 1'b0, 3, 0, -1);
        run_instr(4'b0000, 1'b0, 4, 0, -1);
        do_reset(2);
        run_instr(4'b0001, 1'b0, 0, 3, -1);
        run_instr(4'b0010, 1'b0, 0, 4, -1);
        do_reset(2);
        run_instr(4'b0000, 1'b0, 0, 0, -1);
        run_instr(4'b0010, 1'b0, 0, 3, 2);
        random_run(200);

        // Configuration 1: count wrap, trap, unconditional jump, no timeout.
        sel = 1;
        do_reset(2);
        repeat (5) run_instr(4'b0000, 1'b0, 0, 0, -1);
        run_instr(4'b0101, 1'b0, 0, 0, -1);
        run_instr(4'b0001, 1'b0, 20, 20, -1);
        run_instr(4'b0010, 1'b0, 0, 12, -1);
        run_instr(4'b1011, 1'b0, 0, 0, -1);
        do_reset(2);
        random_run(200);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
